// File: rtl/nn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nn_pkg                                                 |
// | Description : Shared types and helpers for the neural-net datapath:  |
// |               FP32 constants, the matmul sequencer state encoding    |
// |               and a constant-evaluable ceil(log2) helper.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package nn_pkg;

  localparam int          S_FP32   = 32;
  localparam logic [31:0] FP_ONE_5 = 32'h40a00000;  // 5.0 in IEEE-754 single

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

  // ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter                                             |
// | Description : Combinational round-robin pick. Scans req_i starting   |
// |               at ptr_i and wrapping at NREQ; the first set bit wins. |
// | Ports       : req_i    - request vector                              |
// |               ptr_i    - highest-priority index for this pick        |
// |               onehot_o - one-hot winner (0 when no request)          |
// |               idx_o    - winner index (0 when no request)            |
// |               any_o    - at least one request is pending             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arbiter
  import nn_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int            cand;
  logic [IW-1:0] cidx;
  logic          found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cidx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate index ptr+k folded back into 0..NREQ-1 (works for any NREQ).
      cand = int'(ptr_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = IW'(cand);
      if (!found && req_i[cidx]) begin
        found          = 1'b1;
        onehot_o[cidx] = 1'b1;
        idx_o          = cidx;
      end
    end
  end

  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/matmul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : matmul_arbiter                                         |
// | Description : Shares one matmul engine among NREQ requesters. Picks  |
// |               a requester round-robin, latches its operands, pulses  |
// |               the engine start while holding it in reset, runs it    |
// |               until done (or watchdog abort) and returns the result  |
// |               with a one-cycle rsp_valid pulse.                      |
// | Ports       : clk, rst            - clock, sync active-high reset    |
// |               req, a_in, b_in     - requester levels and operands    |
// |               gnt                 - one-hot grant, grant..RESP       |
// |               rsp_valid/err/data  - response to the served requester |
// |               mm_rst_n/start/a/b  - engine control and operands      |
// |               mm_o, mm_done       - engine result and completion     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module matmul_arbiter
  import nn_pkg::*;
#(
  parameter int S       = S_FP32,
  parameter int H       = 2,
  parameter int C       = 2,
  parameter int W       = 2,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*H*C*S-1:0] a_in,
  input  logic [NREQ*C*W*S-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_err,
  output logic [H*W*S-1:0]      rsp_data,
  output logic                  mm_rst_n,
  output logic                  mm_start,
  output logic [H*C*S-1:0]      mm_a,
  output logic [C*W*S-1:0]      mm_b,
  input  logic [H*W*S-1:0]      mm_o,
  input  logic                  mm_done
);

  localparam int AW = H * C * S;
  localparam int BW = C * W * S;
  localparam int OW = H * W * S;
  localparam int IW = (NREQ > 1) ? clog2(NREQ) : 1;
  localparam int CW = clog2(TIMEOUT);

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [OW-1:0]   rsp_data_q, rsp_data_d;
  logic [AW-1:0]   mm_a_q, mm_a_d;
  logic [BW-1:0]   mm_b_q, mm_b_d;
  logic            mm_start_q, mm_start_d;
  logic            mm_rst_n_q, mm_rst_n_d;

  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            timeout;

  logic [AW-1:0]   a_slices [NREQ];
  logic [BW-1:0]   b_slices [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign a_slices[g] = a_in[g*AW +: AW];
    assign b_slices[g] = b_in[g*BW +: BW];
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .onehot_o (win_onehot),
    .idx_o    (win_idx),
    .any_o    (win_any)
  );

  // Last permitted RUN cycle; a done sampled on this same cycle still wins.
  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  // State register plus all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mm_a_q      <= '0;
      mm_b_q      <= '0;
      mm_start_q  <= 1'b0;
      mm_rst_n_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      mm_a_q      <= mm_a_d;
      mm_b_q      <= mm_b_d;
      mm_start_q  <= mm_start_d;
      mm_rst_n_q  <= mm_rst_n_d;
    end
  end

  // Next-state logic. mm_done is not looked at in LOAD, so a done left over
  // from the previous job can never end the new one early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (mm_done || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of every registered output, keyed on the
  // transition being taken so the outputs line up with the new state.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    mm_a_d      = mm_a_q;
    mm_b_d      = mm_b_q;
    mm_start_d  = 1'b0;
    mm_rst_n_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          gnt_d      = win_onehot;
          idx_d      = win_idx;
          mm_a_d     = a_slices[win_idx];
          mm_b_d     = b_slices[win_idx];
          mm_start_d = 1'b1;
        end
      end
      LOAD: begin
        cnt_d      = '0;
        mm_rst_n_d = 1'b1;
      end
      RUN: begin
        cnt_d      = cnt_q + 1'b1;
        mm_rst_n_d = 1'b1;
        if (mm_done) begin
          rsp_data_d  = mm_o;
          rsp_err_d   = 1'b0;
          rsp_valid_d = gnt_q;
          mm_rst_n_d  = 1'b0;
        end else if (timeout) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = gnt_q;
          mm_rst_n_d  = 1'b0;
        end
      end
      RESP: begin
        gnt_d    = '0;
        rr_ptr_d = (int'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign mm_rst_n  = mm_rst_n_q;
  assign mm_start  = mm_start_q;
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_matmul_arbiter                                      |
// | Description : Directed self-checking bench for matmul_arbiter with a |
// |               behavioural 2x2x2 FP32 engine that can complete, hang, |
// |               or complete exactly on the watchdog's last cycle.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_matmul_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [511:0] a_in;
  logic [511:0] b_in;
  logic [3:0]   gnt;
  logic [3:0]   rsp_valid;
  logic         rsp_err;
  logic [127:0] rsp_data;
  logic         mm_rst_n;
  logic         mm_start;
  logic [127:0] mm_a;
  logic [127:0] mm_b;
  logic [127:0] mm_o;
  logic         mm_done;

  int n_cmp  = 0;
  int n_fail = 0;

  matmul_arbiter #(.S(32), .H(2), .C(2), .W(2), .NREQ(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .mm_rst_n  (mm_rst_n),
    .mm_start  (mm_start),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_o      (mm_o),
    .mm_done   (mm_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural engine ----------------
  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [127:0] mm_model(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] o;
    real acc;
    o = '0;
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 2; w++) begin
        acc = 0.0;
        for (int c = 0; c < 2; c++)
          acc = acc + fp2r(a[(r*2+c)*32 +: 32]) * fp2r(b[(c*2+w)*32 +: 32]);
        o[(r*2+w)*32 +: 32] = r2fp(acc);
      end
    end
    return o;
  endfunction

  int         eng_mode;  // 0: done after a few cycles, 1: never done, 2: done on watchdog's last cycle
  logic [7:0] ecnt;
  logic       edone_q;

  always @(posedge clk) begin
    if (!mm_rst_n) begin
      ecnt    <= 8'd0;
      edone_q <= 1'b0;
    end else begin
      ecnt <= ecnt + 8'd1;
      if (eng_mode == 0 && ecnt == 8'd2) edone_q <= 1'b1;
    end
  end

  assign mm_done = (eng_mode == 2) ? (mm_rst_n && ecnt == 8'd15) : edone_q;
  assign mm_o    = mm_model(mm_a, mm_b);

  bit multi_hot_seen;
  always @(negedge clk) if ($countones(gnt) > 1) multi_hot_seen = 1'b1;

  // ---------------- operands and hand-computed products ----------------
  logic [127:0] opA [4];
  logic [127:0] opB [4];
  logic [127:0] resM [4];

  localparam logic [127:0] ALL5  = {4{32'h40a00000}};
  localparam logic [127:0] ALL50 = {4{32'h42480000}};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == 4'd0 && n < 50) begin
      step;
      n++;
    end
  endtask

  task automatic wait_rsp(output int n, output int starts);
    n = 0;
    starts = 0;
    while (rsp_valid == 4'd0 && n < 100) begin
      step;
      n++;
      if (mm_start) starts++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; req = 4'd0; eng_mode = 0;
    a_in = {opA[3], opA[2], opA[1], opA[0]};
    b_in = {opB[3], opB[2], opB[1], opB[0]};
    step; step; step;
    n_cmp++; if (gnt !== 4'd0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (rsp_valid !== 4'd0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: valid %b err %b want 0000/0", rsp_valid, rsp_err); end
    n_cmp++; if (rsp_data !== 128'd0 || mm_a !== 128'd0 || mm_b !== 128'd0) begin n_fail++; $display("FAIL reset_data: data %h a %h b %h want 0", rsp_data, mm_a, mm_b); end
    n_cmp++; if (mm_start !== 1'b0 || mm_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_eng: start %b rst_n %b want 0/0", mm_start, mm_rst_n); end
    rst = 1'b0;
    step;
    n_cmp++; if (gnt !== 4'd0 || mm_rst_n !== 1'b0) begin n_fail++; $display("FAIL idle_quiet: gnt %b rst_n %b want 0000/0", gnt, mm_rst_n); end
  endtask

  task automatic test_single;
    int n, s;
    a_in[127:0] = ALL5; b_in[127:0] = ALL5;
    req = 4'b0001;
    wait_gnt(n);
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    n_cmp++; if (mm_start !== 1'b1 || mm_rst_n !== 1'b0) begin n_fail++; $display("FAIL single_load: start %b rst_n %b want 1/0", mm_start, mm_rst_n); end
    n_cmp++; if (mm_a !== ALL5 || mm_b !== ALL5) begin n_fail++; $display("FAIL single_ops: a %h b %h want %h", mm_a, mm_b, ALL5); end
    req = 4'd0;
    step;
    n_cmp++; if (mm_start !== 1'b0 || mm_rst_n !== 1'b1) begin n_fail++; $display("FAIL single_run: start %b rst_n %b want 0/1", mm_start, mm_rst_n); end
    wait_rsp(n, s);
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b want 0001", rsp_valid); end
    n_cmp++; if (rsp_data !== ALL50 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_data: got %h err %b want %h err 0", rsp_data, rsp_err, ALL50); end
    n_cmp++; if (s !== 0) begin n_fail++; $display("FAIL single_one_start: extra start pulses %0d want 0", s); end
    n_cmp++; if (mm_rst_n !== 1'b0) begin n_fail++; $display("FAIL single_resp_rstn: got %b want 0", mm_rst_n); end
    step;
    n_cmp++; if (rsp_valid !== 4'd0 || gnt !== 4'd0) begin n_fail++; $display("FAIL single_end: valid %b gnt %b want 0000/0000", rsp_valid, gnt); end
    a_in = {opA[3], opA[2], opA[1], opA[0]};
    b_in = {opB[3], opB[2], opB[1], opB[0]};
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    int n, s;
    rst = 1'b1; step; rst = 1'b0;
    multi_hot_seen = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      wait_gnt(n);
      n_cmp++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp_g); end
      n_cmp++; if (mm_a !== opA[k%4] || mm_b !== opB[k%4]) begin n_fail++; $display("FAIL rr_ops[%0d]: a %h want %h", k, mm_a, opA[k%4]); end
      wait_rsp(n, s);
      n_cmp++; if (rsp_valid !== exp_g) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want %b", k, rsp_valid, exp_g); end
      n_cmp++; if (rsp_data !== resM[k%4] || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rr_data[%0d]: got %h err %b want %h", k, rsp_data, rsp_err, resM[k%4]); end
      if (k == 4) req = 4'd0;
      step;
      n_cmp++; if (gnt !== 4'd0 || rsp_valid !== 4'd0) begin n_fail++; $display("FAIL rr_gap[%0d]: gnt %b valid %b want 0000/0000", k, gnt, rsp_valid); end
    end
    n_cmp++; if (multi_hot_seen !== 1'b0) begin n_fail++; $display("FAIL rr_onehot: multi-hot grant seen %b want 0", multi_hot_seen); end
  endtask

  task automatic test_drop_req;
    int n, s;
    req = 4'b0100;
    wait_gnt(n);
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL drop_gnt: got %b want 0100", gnt); end
    req = 4'd0;
    a_in = '1; b_in = '1;
    step; step;
    n_cmp++; if (mm_a !== opA[2] || mm_b !== opB[2]) begin n_fail++; $display("FAIL drop_ops: a %h want %h", mm_a, opA[2]); end
    wait_rsp(n, s);
    n_cmp++; if (rsp_valid !== 4'b0100 || rsp_data !== resM[2]) begin n_fail++; $display("FAIL drop_rsp: valid %b data %h want 0100 %h", rsp_valid, rsp_data, resM[2]); end
    a_in = {opA[3], opA[2], opA[1], opA[0]};
    b_in = {opB[3], opB[2], opB[1], opB[0]};
    step;
  endtask

  task automatic test_timeout;
    int n, s;
    eng_mode = 1;
    req = 4'b0010;
    wait_gnt(n);
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL to_gnt: got %b want 0010", gnt); end
    req = 4'd0;
    wait_rsp(n, s);
    n_cmp++; if (n !== 17) begin n_fail++; $display("FAIL to_latency: %0d edges after grant want 17", n); end
    n_cmp++; if (rsp_valid !== 4'b0010 || rsp_err !== 1'b1 || rsp_data !== 128'd0) begin n_fail++; $display("FAIL to_rsp: valid %b err %b data %h want 0010 1 0", rsp_valid, rsp_err, rsp_data); end
    step;
    eng_mode = 0;
    req = 4'b1000;
    wait_gnt(n);
    n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL to_next_gnt: got %b want 1000", gnt); end
    req = 4'd0;
    wait_rsp(n, s);
    n_cmp++; if (rsp_valid !== 4'b1000 || rsp_err !== 1'b0 || rsp_data !== resM[3]) begin n_fail++; $display("FAIL to_next_rsp: valid %b err %b data %h want 1000 0 %h", rsp_valid, rsp_err, rsp_data, resM[3]); end
    step;
  endtask

  task automatic test_done_at_timeout;
    int n, s;
    eng_mode = 2;
    req = 4'b0001;
    wait_gnt(n);
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL tie_gnt: got %b want 0001", gnt); end
    req = 4'd0;
    wait_rsp(n, s);
    n_cmp++; if (n !== 17) begin n_fail++; $display("FAIL tie_latency: %0d edges after grant want 17", n); end
    n_cmp++; if (rsp_err !== 1'b0 || rsp_data !== resM[0] || rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL tie_rsp: valid %b err %b data %h want 0001 0 %h", rsp_valid, rsp_err, rsp_data, resM[0]); end
    step;
    eng_mode = 0;
  endtask

  task automatic test_reset_mid_run;
    int n, s, pulses;
    eng_mode = 1;
    req = 4'b0100;
    wait_gnt(n);
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
    req = 4'd0;
    for (int i = 0; i < 5; i++) step;
    n_cmp++; if (mm_rst_n !== 1'b1) begin n_fail++; $display("FAIL mid_running: rst_n %b want 1", mm_rst_n); end
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_cmp++; if (gnt !== 4'd0 || mm_rst_n !== 1'b0 || rsp_valid !== 4'd0) begin n_fail++; $display("FAIL mid_reset: gnt %b rst_n %b valid %b want 0000/0/0000", gnt, mm_rst_n, rsp_valid); end
    n_cmp++; if (rsp_data !== 128'd0 || mm_start !== 1'b0) begin n_fail++; $display("FAIL mid_reset_data: data %h start %b want 0/0", rsp_data, mm_start); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      if (rsp_valid !== 4'd0) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_no_rsp: %0d response cycles want 0", pulses); end
    eng_mode = 0;
    req = 4'b1001;
    wait_gnt(n);
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_zero: got %b want 0001", gnt); end
    req = 4'd0;
    wait_rsp(n, s);
    n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data !== resM[0]) begin n_fail++; $display("FAIL mid_after_rsp: valid %b data %h want 0001 %h", rsp_valid, rsp_data, resM[0]); end
    step;
    req = 4'b1000;
    wait_gnt(n);
    n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_fresh_gnt: got %b want 1000", gnt); end
    req = 4'd0;
    wait_rsp(n, s);
    n_cmp++; if (rsp_valid !== 4'b1000 || rsp_err !== 1'b0 || rsp_data !== resM[3]) begin n_fail++; $display("FAIL mid_fresh_rsp: valid %b err %b data %h want 1000 0 %h", rsp_valid, rsp_err, rsp_data, resM[3]); end
    step;
  endtask

  initial begin
    // Elements listed high-to-low: {e11, e10, e01, e00}.
    opA[0]  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000};  // [[1,2],[3,4]]
    opB[0]  = {32'h3f800000, 32'h00000000, 32'h00000000, 32'h3f800000};  // identity
    resM[0] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3f800000};  // [[1,2],[3,4]]
    opA[1]  = {32'h40400000, 32'h40000000, 32'h3f800000, 32'hbf4ac269};  // [[-0.792,1],[2,3]]
    opB[1]  = {32'h40800000, 32'h40000000, 32'h00000000, 32'h00000000};  // [[0,0],[2,4]]
    resM[1] = {32'h41400000, 32'h40c00000, 32'h40800000, 32'h40000000};  // [[2,4],[6,12]]
    opA[2]  = {32'h40000000, 32'h00000000, 32'h00000000, 32'h40000000};  // [[2,0],[0,2]]
    opB[2]  = {32'h40400000, 32'h3f000000, 32'hbf800000, 32'h3fc00000};  // [[1.5,-1],[0.5,3]]
    resM[2] = {32'h40c00000, 32'h3f800000, 32'hc0000000, 32'h40400000};  // [[3,-2],[1,6]]
    opA[3]  = {32'h3f800000, 32'h3f800000, 32'h3f800000, 32'hbf800000};  // [[-1,1],[1,1]]
    opB[3]  = {32'h41000000, 32'h40800000, 32'h40000000, 32'h40000000};  // [[2,2],[4,8]]
    resM[3] = {32'h41200000, 32'h40c00000, 32'h40c00000, 32'h40000000};  // [[2,6],[6,10]]

    test_reset;
    test_single;
    test_round_robin;
    test_drop_req;
    test_timeout;
    test_done_at_timeout;
    test_reset_mid_run;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
